spi_write_multi: RTL and testbench

- Parametrised SPI write master; successor of the fixed 8-bit, single-CS write IP.
- Serialises a Width-bit command onto mosi_o with a run-time programmable SCLK divider.
- Selects one of NumCs active-low chip selects, with selectable idle clock polarity (CPOL) and bit order; data is always CPHA=0.
- Sits between the acquisition controller and external DAC/ADC devices; one frame per start request, back-to-back capable.

---
 rtl/spi_write_multi.sv | 169 ++++++++++++++++
 tb/tb_spi_write_multi.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_write_multi.sv
// SPI write master: serialises one Width-bit command per start request onto one of
// NumCs active-low chip selects, CPHA=0, with programmable CPOL, bit order and SCLK divider.
module spi_write_multi #(
   parameter int Width    = 8,
   parameter int NumCs    = 4,
   parameter int SelWidth = 2,
   parameter int DivWidth = 8
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                strw_i,
   input  logic [Width-1:0]    cmd_i,
   input  logic [DivWidth-1:0] kmax_i,
   input  logic [SelWidth-1:0] cs_sel_i,
   input  logic                cpol_i,
   input  logic                lsb_first_i,
   output logic                mosi_o,
   output logic                dclk_o,
   output logic [NumCs-1:0]    cs_o,
   output logic                busy_o,
   output logic                eow_o,
   output logic                err_o
);

   localparam int                BitW    = $clog2(Width + 1);
   localparam logic [SelWidth:0] NumCsW  = (SelWidth + 1)'(NumCs);
   localparam logic [BitW-1:0]   LastBit = BitW'(Width - 1);

   typedef enum logic [2:0] {IDLE, LEAD, HI, LO, TRAIL} state_t;

   state_t              state, state_n;
   logic [DivWidth-1:0] cnt, cnt_n;
   logic [DivWidth-1:0] kmax_q, kmax_n;
   logic [BitW-1:0]     bit_cnt, bit_cnt_n;
   logic                cpol_q, cpol_n;
   logic                lsb_q, lsb_n;
   logic [Width-1:0]    shreg, shreg_n, shifted;
   logic                mosi_n, dclk_n, busy_n, eow_n, err_n;
   logic [NumCs-1:0]    cs_n;
   logic                tick, sel_ok;

   function automatic logic [NumCs-1:0] cs_decode(input logic [SelWidth-1:0] sel);
      logic [NumCs-1:0] cs;
      cs = '1;
      for (int i = 0; i < NumCs; i++) begin
         if (sel == SelWidth'(i)) cs[i] = 1'b0;
      end
      return cs;
   endfunction

   function automatic logic pick_bit(input logic [Width-1:0] data, input logic lsb);
      return lsb ? data[0] : data[Width-1];
   endfunction

   assign tick   = (cnt == kmax_q);
   assign sel_ok = ({1'b0, cs_sel_i} < NumCsW);

   always_comb begin
      state_n   = state;
      cnt_n     = tick ? '0 : cnt + DivWidth'(1);
      kmax_n    = kmax_q;
      bit_cnt_n = bit_cnt;
      cpol_n    = cpol_q;
      lsb_n     = lsb_q;
      shreg_n   = shreg;
      shifted   = lsb_q ? (shreg >> 1) : (shreg << 1);
      mosi_n    = mosi_o;
      dclk_n    = dclk_o;
      cs_n      = cs_o;
      busy_n    = busy_o;
      eow_n     = 1'b0;
      err_n     = 1'b0;

      unique case (state)
         IDLE: begin
            cnt_n  = '0;
            dclk_n = cpol_q;
            cs_n   = '1;
            busy_n = 1'b0;
            if (strw_i && sel_ok) begin
               // Outputs are registered, so the first LEAD cycle is prepared here
               state_n   = LEAD;
               kmax_n    = kmax_i;
               cpol_n    = cpol_i;
               lsb_n     = lsb_first_i;
               shreg_n   = cmd_i;
               bit_cnt_n = '0;
               mosi_n    = pick_bit(cmd_i, lsb_first_i);
               dclk_n    = cpol_i;
               cs_n      = cs_decode(cs_sel_i);
               busy_n    = 1'b1;
            end else if (strw_i) begin
               err_n = 1'b1;
            end
         end
         LEAD: begin
            if (tick) begin
               dclk_n  = ~cpol_q;
               state_n = HI;
            end
         end
         HI: begin
            if (tick) begin
               dclk_n    = cpol_q;
               bit_cnt_n = bit_cnt + BitW'(1);
               if (bit_cnt == LastBit) begin
                  state_n = TRAIL;
               end else begin
                  shreg_n = shifted;
                  mosi_n  = pick_bit(shifted, lsb_q);
                  state_n = LO;
               end
            end
         end
         LO: begin
            if (tick) begin
               dclk_n  = ~cpol_q;
               state_n = HI;
            end
         end
         TRAIL: begin
            if (tick) begin
               cs_n    = '1;
               mosi_n  = 1'b0;
               busy_n  = 1'b0;
               eow_n   = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state   <= IDLE;
         cnt     <= '0;
         kmax_q  <= '0;
         bit_cnt <= '0;
         cpol_q  <= 1'b0;
         lsb_q   <= 1'b0;
         mosi_o  <= 1'b0;
         dclk_o  <= 1'b0;
         cs_o    <= '1;
         busy_o  <= 1'b0;
         eow_o   <= 1'b0;
         err_o   <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         kmax_q  <= kmax_n;
         bit_cnt <= bit_cnt_n;
         cpol_q  <= cpol_n;
         lsb_q   <= lsb_n;
         mosi_o  <= mosi_n;
         dclk_o  <= dclk_n;
         cs_o    <= cs_n;
         busy_o  <= busy_n;
         eow_o   <= eow_n;
         err_o   <= err_n;
      end
   end

   // Shift data is only meaningful inside a frame and needs no reset
   always_ff @(posedge clk_i) begin
      shreg <= shreg_n;
   end

endmodule

// File: tb/tb_spi_write_multi.sv
// Scoreboard bench for spi_write_multi: stimulus queues expected frames/errors,
// monitors reconstruct each frame from the pins and compare on eow_o / err_o.
module tb_spi_write_multi;

   logic       clk = 1'b0;
   logic       rst;
   logic       strw, strw3;
   logic [7:0] cmd, kmax;
   logic [1:0] sel;
   logic       cpol, lsb;

   logic       mosi, dclk, busy, eow, err;
   logic [3:0] cs;
   logic       mosi3, dclk3, busy3, eow3, err3;
   logic [2:0] cs3;

   always #5 clk = ~clk;

   spi_write_multi #(.Width(8), .NumCs(4), .SelWidth(2), .DivWidth(8)) dut (
      .clk_i(clk), .rst_i(rst), .strw_i(strw), .cmd_i(cmd), .kmax_i(kmax),
      .cs_sel_i(sel), .cpol_i(cpol), .lsb_first_i(lsb),
      .mosi_o(mosi), .dclk_o(dclk), .cs_o(cs), .busy_o(busy), .eow_o(eow), .err_o(err)
   );

   spi_write_multi #(.Width(8), .NumCs(3), .SelWidth(2), .DivWidth(8)) dut3 (
      .clk_i(clk), .rst_i(rst), .strw_i(strw3), .cmd_i(cmd), .kmax_i(kmax),
      .cs_sel_i(sel), .cpol_i(cpol), .lsb_first_i(lsb),
      .mosi_o(mosi3), .dclk_o(dclk3), .cs_o(cs3), .busy_o(busy3), .eow_o(eow3), .err_o(err3)
   );

   typedef struct {
      logic [31:0] bits;
      int          nb;
      logic [3:0]  cs;
      int          len;
      int          ph;
      int          gap;
   } exp_t;

   exp_t exp_q[$];
   int   q3[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   // Main-DUT monitor state
   logic        act_c, prev_act, lead_lvl, prev_d;
   logic [31:0] rx;
   logic [3:0]  cs_seen;
   logic        cs_bad;
   int          nb, len, busy_cnt, run, pmin, pmax, gap, idle_run;
   int          onehot_bad = 0;
   logic        main_err_seen = 1'b0;
   exp_t        e;

   initial begin : monitor
      prev_act = 1'b0;
      idle_run = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev_act = 1'b0;
            idle_run = 0;
         end else begin
            act_c = (cs != 4'hF);
            if ($countones(~cs) > 1) onehot_bad++;
            if (err) main_err_seen = 1'b1;
            if (act_c && !prev_act) begin
               lead_lvl = dclk;
               prev_d   = dclk;
               rx       = '0;
               nb       = 0;
               len      = 0;
               busy_cnt = 0;
               cs_seen  = cs;
               cs_bad   = 1'b0;
               run      = 0;
               pmin     = 1 << 30;
               pmax     = 0;
               gap      = idle_run;
            end
            if (busy) busy_cnt++;
            if (act_c) begin
               len++;
               idle_run = 0;
               if (cs != cs_seen) cs_bad = 1'b1;
               if (dclk != prev_d && dclk != lead_lvl) begin
                  rx = {rx[30:0], mosi};
                  nb++;
               end
               if (dclk != lead_lvl) begin
                  run++;
               end else if (run != 0) begin
                  if (run < pmin) pmin = run;
                  if (run > pmax) pmax = run;
                  run = 0;
               end
               prev_d = dclk;
            end else begin
               idle_run++;
            end
            prev_act = act_c;
            if (eow) begin
               chk("eow_expected", 32'(exp_q.size() > 0), 32'd1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  chk("bit_count", nb, e.nb);
                  chk("bits", rx, e.bits);
                  chk("cs_active", {28'd0, cs_seen}, {28'd0, e.cs});
                  chk("cs_stable", {31'd0, cs_bad}, 32'd0);
                  chk("cs_low_cycles", len, e.len);
                  chk("busy_cycles", busy_cnt, e.len);
                  chk("phase_min", pmin, e.ph);
                  chk("phase_max", pmax, e.ph);
                  if (e.gap != 0) chk("cs_gap", gap, e.gap);
                  chk("eow_cs_idle", {28'd0, cs}, 32'hF);
                  chk("eow_busy", {31'd0, busy}, 32'd0);
               end
            end
         end
      end
   end

   // Second DUT (NumCs=3): only ever sees rejected requests
   logic err3_prev = 1'b0;
   logic err3_long = 1'b0;
   logic quiet3_bad = 1'b0;

   initial begin : monitor3
      forever begin
         @(negedge clk);
         if (rst) begin
            if (busy3 || eow3 || mosi3 || dclk3 || cs3 != 3'b111) quiet3_bad = 1'b1;
            if (err3 && err3_prev) err3_long = 1'b1;
            if (err3) begin
               chk("err_expected", 32'(q3.size() > 0), 32'd1);
               if (q3.size() > 0) begin
                  void'(q3.pop_front());
                  chk("err_cs_idle", {29'd0, cs3}, 32'h7);
                  chk("err_busy", {31'd0, busy3}, 32'd0);
               end
            end
            err3_prev = err3;
         end else begin
            err3_prev = 1'b0;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_eow(input string name, input int max);
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (eow) return;
      end
      chk({name, "_timeout"}, 32'd1, 32'd0);
   endtask

   task automatic push_exp(input logic [31:0] bits, input logic [3:0] ecs,
                           input int elen, input int eph, input int egap);
      exp_t x;
      x.bits = bits;
      x.nb   = 8;
      x.cs   = ecs;
      x.len  = elen;
      x.ph   = eph;
      x.gap  = egap;
      exp_q.push_back(x);
   endtask

   task automatic send(input logic [7:0] c, input logic [7:0] k, input logic [1:0] s,
                       input logic cp, input logic lf);
      cmd  = c;
      kmax = k;
      sel  = s;
      cpol = cp;
      lsb  = lf;
      strw = 1'b1;
      step(1);
      strw = 1'b0;
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int   acc;
      logic pb;
      int   edges;
      logic pd;

      rst = 1'b0; strw = 1'b0; strw3 = 1'b0;
      cmd = '0; kmax = '0; sel = '0; cpol = 1'b0; lsb = 1'b0;
      step(3);
      chk("rst_mosi", {31'd0, mosi}, 32'd0);
      chk("rst_dclk", {31'd0, dclk}, 32'd0);
      chk("rst_cs", {28'd0, cs}, 32'hF);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_eow", {31'd0, eow}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      rst = 1'b1;
      step(2);

      // MSB first, sel 0, with mid-frame input changes and an ignored strobe
      push_exp(32'h97, 4'b1110, 34, 2, 0);
      send(8'h97, 8'd1, 2'd0, 1'b0, 1'b0);
      step(5);
      cmd = 8'h00; kmax = 8'd0; sel = 2'd1; cpol = 1'b1; lsb = 1'b1;
      strw = 1'b1;
      step(1);
      strw = 1'b0;
      wait_eow("msb", 100);
      step(3);

      // LSB first, CPOL=1, sel 2
      push_exp(32'hE9, 4'b1011, 34, 2, 0);
      send(8'h97, 8'd1, 2'd2, 1'b1, 1'b1);
      wait_eow("lsb", 100);
      chk("idle_dclk_cpol1", {31'd0, dclk}, 32'd1);
      step(3);

      // Divider extremes
      push_exp(32'h3C, 4'b1101, 17, 1, 0);
      send(8'h3C, 8'd0, 2'd1, 1'b0, 1'b0);
      wait_eow("kmax0", 60);
      step(2);
      push_exp(32'hC5, 4'b0111, 4352, 256, 0);
      send(8'hC5, 8'd255, 2'd3, 1'b0, 1'b0);
      wait_eow("kmax255", 5000);
      step(2);

      // Back-to-back with strw held high
      push_exp(32'hA5, 4'b1110, 17, 1, 0);
      push_exp(32'hA5, 4'b1110, 17, 1, 1);
      push_exp(32'hA5, 4'b1110, 17, 1, 1);
      cmd = 8'hA5; kmax = 8'd0; sel = 2'd0; cpol = 1'b0; lsb = 1'b0;
      strw = 1'b1;
      acc = 0;
      pb  = busy;
      for (int i = 0; i < 300 && acc < 3; i++) begin
         @(negedge clk);
         if (busy && !pb) acc++;
         pb = busy;
      end
      chk("b2b_accepts", acc, 3);
      step(1);
      strw = 1'b0;
      wait_eow("b2b", 100);
      step(3);

      // Rejected chip select on the 3-CS instance
      q3.push_back(1);
      sel   = 2'd3;
      strw3 = 1'b1;
      step(1);
      strw3 = 1'b0;
      step(6);

      // Reset during bit 4, then a normal frame
      send(8'h5A, 8'd1, 2'd1, 1'b0, 1'b0);
      edges = 0;
      pd    = dclk;
      for (int i = 0; i < 100 && edges < 4; i++) begin
         @(negedge clk);
         if (dclk && !pd) edges++;
         pd = dclk;
      end
      chk("abort_edges", edges, 4);
      step(1);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("abort_cs", {28'd0, cs}, 32'hF);
      chk("abort_dclk", {31'd0, dclk}, 32'd0);
      chk("abort_mosi", {31'd0, mosi}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_eow", {31'd0, eow}, 32'd0);
      step(1);
      rst = 1'b1;
      step(40);
      push_exp(32'h5A, 4'b1101, 34, 2, 0);
      send(8'h5A, 8'd1, 2'd1, 1'b0, 1'b0);
      wait_eow("post_reset", 100);
      step(5);

      chk("exp_queue_empty", exp_q.size(), 0);
      chk("err_queue_empty", q3.size(), 0);
      chk("cs_onehot", onehot_bad, 0);
      chk("main_no_err", {31'd0, main_err_seen}, 32'd0);
      chk("err_pulse_width", {31'd0, err3_long}, 32'd0);
      chk("cs3_quiet", {31'd0, quiet3_bad}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
